// File: rtl/run_controller.sv
// Run/handshake controller: programmable clock-enable divider, done-address table,
// 4-phase req/ack handshake, per-run tick counter and watchdog timeout.
module run_controller #(
    parameter int PC_BITS   = 10,
    parameter int NUM_PROGS = 4,
    parameter int DIV_BITS  = 4,
    parameter int CYC_BITS  = 16,
    localparam int SEL_W    = $clog2(NUM_PROGS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req,
    input  logic [SEL_W-1:0]    prog_sel,
    input  logic                da_we,
    input  logic [SEL_W-1:0]    da_wsel,
    input  logic [PC_BITS-1:0]  da_wdata,
    input  logic [DIV_BITS-1:0] div_ratio,
    input  logic [CYC_BITS-1:0] timeout_cycles,
    input  logic [PC_BITS-1:0]  pc,
    output logic                core_en,
    output logic                core_start,
    output logic                busy,
    output logic                ack,
    output logic                timeout,
    output logic [CYC_BITS-1:0] cycle_count
);

    typedef enum logic [2:0] {IDLE, START, RUN, DONE, ABORT} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DIV_BITS-1:0] div_q, div_d;
    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic [CYC_BITS-1:0] count_q, count_d, count_inc;
    logic                en_q, en_d;
    logic                start_q, start_d;
    logic                ack_q, ack_d;
    logic                to_q, to_d;
    logic [PC_BITS-1:0]  table_q [NUM_PROGS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PROGS; i++) table_q[i] <= '1;
        end else if (da_we) begin
            table_q[da_wsel] <= da_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            start_q <= 1'b0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            en_q    <= en_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            to_q    <= to_d;
        end
    end

    // en_d looks one cycle ahead so core_en is a plain register with no input path.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        count_d   = count_q;
        en_d      = 1'b0;
        start_d   = 1'b0;
        ack_d     = 1'b0;
        to_d      = 1'b0;
        count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = START;
                    sel_d   = prog_sel;
                    div_d   = div_ratio;
                    cnt_d   = '0;
                    count_d = '0;
                    en_d    = (div_ratio == '0);
                    start_d = (div_ratio == '0);
                end
            end
            START, RUN: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (en_q) begin
                    count_d = count_inc;
                    if (pc == table_q[sel_q]) begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                    end else if (timeout_cycles != '0 && count_inc == timeout_cycles) begin
                        state_d = ABORT;
                        ack_d   = 1'b1;
                        to_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        en_d    = (div_q == '0);
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    en_d    = (cnt_d == div_q);
                    start_d = (cnt_d == div_q) && (state_q == START);
                end
            end
            DONE: begin
                if (!req) state_d = IDLE;
                else      ack_d   = 1'b1;
            end
            ABORT: begin
                if (!req) begin
                    state_d = IDLE;
                end else begin
                    ack_d = 1'b1;
                    to_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_en     = en_q;
    assign core_start  = start_q;
    assign busy        = (state_q == START) || (state_q == RUN);
    assign ack         = ack_q;
    assign timeout     = to_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a tick-schedule reference model.
module tb_run_controller;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  prog_sel = '0;
    logic        da_we = 1'b0;
    logic [1:0]  da_wsel = '0;
    logic [9:0]  da_wdata = '0;
    logic [3:0]  div_ratio = '0;
    logic [15:0] timeout_cycles = '0;
    logic [9:0]  pc = '0;
    logic        core_en, core_start, busy, ack, timeout;
    logic [15:0] cycle_count;

    int checks = 0;
    int failures = 0;
    int pc_base = 0;

    run_controller dut (
        .clock(clock), .reset_n(reset_n), .req(req), .prog_sel(prog_sel),
        .da_we(da_we), .da_wsel(da_wsel), .da_wdata(da_wdata),
        .div_ratio(div_ratio), .timeout_cycles(timeout_cycles), .pc(pc),
        .core_en(core_en), .core_start(core_start), .busy(busy), .ack(ack),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: run is idle / active / acknowledged; ticks fall on every
    // (div+1)-th clock of the active period, counted from the clock req was taken.
    int         m_mode = 0;
    int         m_k = 0, m_div = 0, m_sel = 0, m_count = 0;
    bit         m_abort = 0;
    bit         tick;
    logic [9:0] m_tbl [4];
    logic       e_en = 0, e_start = 0;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_mode = 0; m_count = 0; m_abort = 0; m_k = 0;
            e_en = 0; e_start = 0;
            for (int i = 0; i < 4; i++) m_tbl[i] = 10'h3FF;
        end else begin
            tick = e_en;
            case (m_mode)
                0: if (req) begin
                    m_mode = 1; m_k = 0; m_count = 0;
                    m_div = int'(div_ratio); m_sel = int'(prog_sel);
                end
                1: if (!req) m_mode = 0;
                   else begin
                       if (tick) begin
                           if (m_count < 65535) m_count++;
                           if (pc == m_tbl[m_sel]) begin
                               m_mode = 2; m_abort = 0;
                           end else if (timeout_cycles != 0 && m_count == int'(timeout_cycles)) begin
                               m_mode = 2; m_abort = 1;
                           end
                       end
                       m_k++;
                   end
                default: if (!req) m_mode = 0;
            endcase
            if (da_we) m_tbl[da_wsel] = da_wdata;
            e_en    = (m_mode == 1) && (m_k % (m_div + 1) == m_div);
            e_start = e_en && (m_k == m_div);
        end
        #2;
        chk("core_en", 32'(core_en), 32'(e_en));
        chk("core_start", 32'(core_start), 32'(e_start));
        chk("busy", 32'(busy), 32'(m_mode == 1));
        chk("ack", 32'(ack), 32'(m_mode == 2));
        chk("timeout", 32'(timeout), 32'(m_mode == 2 && m_abort));
        chk("cycle_count", 32'(cycle_count), 32'(m_count));
        pc = 10'(pc_base + m_count);
    end

    task automatic wait_ack(input string name, input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            if (ack) seen = 1;
        end
        if (!seen) chk({name, "_ack_wait"}, 32'(seen), 32'd1);
    endtask

    task automatic wr_table(input logic [1:0] sel, input logic [9:0] val);
        @(negedge clock);
        da_we = 1'b1; da_wsel = sel; da_wdata = val;
        @(negedge clock);
        da_we = 1'b0;
    endtask

    task automatic end_run();
        req = 1'b0;
        @(negedge clock);
        chk("ack_released", 32'(ack), 32'd0);
        @(negedge clock);
    endtask

    int en_seen;
    logic en_first [3];

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_count", 32'(cycle_count), 32'd0);
        reset_n = 1'b1;

        // div 0, table[0]=3, pc 0..3
        wr_table(2'd0, 10'd3);
        prog_sel = 0; div_ratio = 0; timeout_cycles = 0; pc_base = 0;
        @(negedge clock);
        req = 1'b1;
        @(negedge clock);
        chk("t1_first_en", 32'(core_en), 32'd1);
        chk("t1_first_start", 32'(core_start), 32'd1);
        wait_ack("t1", 40);
        chk("t1_count", 32'(cycle_count), 32'd4);
        chk("t1_timeout", 32'(timeout), 32'd0);
        end_run();

        // div 2: one tick per three clocks, then drop req mid-run
        div_ratio = 2; pc_base = 100;
        req = 1'b1;
        en_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (i < 3) en_first[i] = core_en;
            if (core_en) en_seen++;
        end
        chk("t2_en_k0", 32'(en_first[0]), 32'd0);
        chk("t2_en_k1", 32'(en_first[1]), 32'd0);
        chk("t2_en_k2", 32'(en_first[2]), 32'd1);
        chk("t2_en_rate", 32'(en_seen), 32'd4);
        req = 1'b0;
        @(negedge clock);
        chk("t2_drop_en", 32'(core_en), 32'd0);
        chk("t2_drop_busy", 32'(busy), 32'd0);
        chk("t2_drop_count", 32'(cycle_count), 32'd3);
        repeat (3) @(negedge clock);
        chk("t2_no_ack", 32'(ack), 32'd0);

        // restart clears count; watchdog at 5 ticks
        timeout_cycles = 5;
        req = 1'b1;
        @(negedge clock);
        chk("t4_restart_count", 32'(cycle_count), 32'd0);
        wait_ack("t3a", 60);
        chk("t3a_timeout", 32'(timeout), 32'd1);
        chk("t3a_count", 32'(cycle_count), 32'd5);
        end_run();
        wr_table(2'd0, 10'd104);
        req = 1'b1;
        wait_ack("t3b", 60);
        chk("t3b_timeout", 32'(timeout), 32'd0);
        chk("t3b_count", 32'(cycle_count), 32'd5);
        end_run();

        // live table rewrite on the running entry; prog_sel change ignored
        timeout_cycles = 0; div_ratio = 0; pc_base = 10;
        wr_table(2'd1, 10'd500);
        prog_sel = 1;
        req = 1'b1;
        repeat (3) @(negedge clock);
        da_we = 1'b1; da_wsel = 2'd1; da_wdata = 10'd15; prog_sel = 0;
        @(negedge clock);
        da_we = 1'b0;
        wait_ack("t5", 40);
        chk("t5_count", 32'(cycle_count), 32'd6);
        end_run();

        // asynchronous reset mid-run restores table to all ones
        div_ratio = 1; pc_base = 0;
        req = 1'b1;
        repeat (4) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_en", 32'(core_en), 32'd0);
        chk("t6_rst_start", 32'(core_start), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ack", 32'(ack), 32'd0);
        chk("t6_rst_count", 32'(cycle_count), 32'd0);
        req = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        div_ratio = 0; prog_sel = 2; pc_base = 1020;
        @(negedge clock);
        req = 1'b1;
        wait_ack("t6", 40);
        chk("t6_table_ones", 32'(cycle_count), 32'd4);
        end_run();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            da_we    = ($urandom_range(0, 9) == 0);
            da_wsel  = 2'($urandom_range(0, 3));
            da_wdata = 10'($urandom_range(0, 40));
            prog_sel = 2'($urandom_range(0, 3));
            div_ratio = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0)
                timeout_cycles = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            if (m_mode == 0) begin
                pc_base = $urandom_range(0, 20);
                req = ($urandom_range(0, 3) == 0);
            end else if (m_mode == 1) begin
                if ($urandom_range(0, 49) == 0) req = 1'b0;
            end else begin
                if ($urandom_range(0, 1) == 0) req = 1'b0;
            end
            @(negedge clock);
        end
        req = 1'b0; da_we = 1'b0;
        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
